// File: rtl/reg_mux3.sv
// Registered 3-to-1 word multiplexer. One of A/B/C is picked by S and captured in Y
// on each rising clock edge. S = 3 loads all-zeros.
module reg_mux3 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Y
);

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  // S = 3 is a defined zero case, so synthesis gets no don't-care freedom here
  always_comb begin
    y_d = '0;
    unique case (S)
      2'd0:    y_d = A;
      2'd1:    y_d = B;
      2'd2:    y_d = C;
      2'd3:    y_d = '0;
      default: y_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_reg_mux3.sv
// Self-checking bench for reg_mux3: directed vector table, hand-written reset and
// sampling sequences, random regression against a source-array model, walking ones.
module tb_reg_mux3;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             arst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [1:0]       s;
  logic [WIDTH-1:0] y;

  int checks;
  int failures;

  reg_mux3 #(
    .WIDTH(WIDTH)
  ) dut (
    .clk (clk),
    .arst(arst),
    .A   (a),
    .B   (b),
    .C   (c),
    .S   (s),
    .Y   (y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]       s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: Y=%h expected %h", name, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the value each select code picks, straight from the select table.
  function automatic logic [WIDTH-1:0] model(input logic [1:0] sel, input logic [WIDTH-1:0] va,
                                             input logic [WIDTH-1:0] vb,
                                             input logic [WIDTH-1:0] vc);
    logic [WIDTH-1:0] srcs[4];
    srcs[0] = va;
    srcs[1] = vb;
    srcs[2] = vc;
    srcs[3] = '0;
    return srcs[sel];
  endfunction

  initial begin
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] pat;
    checks   = 0;
    failures = 0;

    vecs[0] = '{s: 2'd0, a: 32'h1111_1111, b: 32'h2222_2222, c: 32'h3333_3333,
                exp: 32'h1111_1111};
    vecs[1] = '{s: 2'd1, a: 32'h1111_1111, b: 32'h2222_2222, c: 32'h3333_3333,
                exp: 32'h2222_2222};
    vecs[2] = '{s: 2'd2, a: 32'h1111_1111, b: 32'h2222_2222, c: 32'h3333_3333,
                exp: 32'h3333_3333};
    vecs[3] = '{s: 2'd3, a: 32'h1111_1111, b: 32'h2222_2222, c: 32'h3333_3333,
                exp: 32'h0000_0000};
    vecs[4] = '{s: 2'd2, a: 32'h0, b: 32'h0, c: 32'h8000_0000, exp: 32'h8000_0000};
    vecs[5] = '{s: 2'd3, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, c: 32'hFFFF_FFFF,
                exp: 32'h0000_0000};

    // Reset held with A all-ones selected: clock edges must be ignored.
    arst = 1'b0;
    a    = 32'hFFFF_FFFF;
    b    = '0;
    c    = '0;
    s    = 2'd0;
    #2;
    check("reset_initial", y, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", y, '0);
    end
    arst = 1'b1;
    #2;
    check("release_no_edge", y, '0);
    tick();
    check("release_first_edge", y, 32'hFFFF_FFFF);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      s = vecs[i].s;
      a = vecs[i].a;
      b = vecs[i].b;
      c = vecs[i].c;
      tick();
      check($sformatf("table[%0d]", i), y, vecs[i].exp);
    end

    // Sampling: B change between edges is invisible until the next edge.
    s = 2'd1;
    b = 32'd5;
    tick();
    check("latency_b5", y, 32'd5);
    b = 32'd7;
    #2;
    check("latency_hold", y, 32'd5);
    a = 32'hA5A5_5A5A;
    tick();
    check("latency_b7", y, 32'd7);
    a = 32'h0F0F_0F0F;
    tick();
    check("unselected_a", y, 32'd7);

    // Asynchronous reset between edges.
    s = 2'd0;
    a = 32'hDEAD_BEEF;
    tick();
    check("load_deadbeef", y, 32'hDEAD_BEEF);
    #2;
    arst = 1'b0;
    #1;
    check("async_clear", y, '0);
    s = 2'd2;
    c = 32'h0000_00C0;
    tick();
    check("async_held", y, '0);
    arst = 1'b1;
    #1;
    check("async_release_no_edge", y, '0);
    tick();
    check("async_release_load", y, 32'h0000_00C0);

    // Random regression.
    for (int i = 0; i < 128; i++) begin
      a = $urandom;
      b = $urandom;
      c = $urandom;
      s = 2'(i % 4);
      exp = model(s, a, b, c);
      tick();
      check($sformatf("random[%0d]", i), y, exp);
    end

    // Walking ones on each source under its matching select.
    for (int src = 0; src < 3; src++) begin
      for (int bit_i = 0; bit_i < WIDTH; bit_i++) begin
        pat = '0;
        pat[bit_i] = 1'b1;
        a = (src == 0) ? pat : ~pat;
        b = (src == 1) ? pat : ~pat;
        c = (src == 2) ? pat : ~pat;
        s = 2'(src);
        tick();
        check($sformatf("walk src%0d bit%0d", src, bit_i), y, pat);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_mux3.md
# reg_mux3

Registered 3-to-1 word multiplexer: one of three 32-bit data inputs is chosen by a 2-bit select, and the result is captured in an output register on each rising clock edge. It is a leaf datapath element used wherever a clean, glitch-free registered select is required between three sources. It also serves as a small reference design for the synthesis flow.

## Interface
- WIDTH, 32, data width of A, B, C and Y (the default configuration is 32)
- clk  input  1  rising-edge clock; only clock in the block
- arst  input  1  asynchronous, active-low reset (0 = reset asserted)
- A  input  WIDTH  data source selected when S = 2'd0
- B  input  WIDTH  data source selected when S = 2'd1
- C  input  WIDTH  data source selected when S = 2'd2
- S  input  2  select code
- Y  output  WIDTH  registered mux output

## Operation
- Combinational select:
  - S = 0 -> A
  - S = 1 -> B
  - S = 2 -> C
  - S = 3 -> all-zeros
- Next-state logic: on every rising edge of clk with arst = 1, Y <= selected value.
- No enable: Y updates on every clock edge.
- Data passes unmodified, with no sign or width conversion; all WIDTH bits are copied verbatim.
- Reset behaviour:
  - arst = 0 forces Y = 0 immediately, independent of clk.
  - Y stays 0 for as long as arst = 0.
  - Clock edges while reset is asserted are ignored.
- Reset release: the first rising clk edge with arst = 1 loads the selected value.
- No X-propagation handling is required beyond standard RTL semantics. For synthesis, S = 3 is a defined case (output zero), not a don't-care.

## Timing
- Latency: 1 clock. Y reflects A/B/C/S as sampled at the rising edge and holds until the next edge.
- Changes to A, B, C or S between edges have no effect on Y until the next rising edge.
- Reset assertion is asynchronous: Y goes to 0 within the same delta/cycle, with no clock needed.
- Reset deassertion is synchronous in effect: Y is first loaded at the next rising edge after arst rises.
- Reset asserted mid-operation clears Y at once. Any pending value is discarded; the register does not retain it after release.
- The output is a direct flop output, with no combinational path from inputs to Y.
- Single clock domain; inputs are assumed synchronous to clk, with setup and hold met.

## Test plan
- Reset:
  - Drive arst = 0 with A = 32'hFFFF_FFFF and S = 0, then toggle clk 3 times -> Y = 0 throughout.
  - Set arst = 1 and apply one rising edge -> Y = 32'hFFFF_FFFF.
- Select sweep:
  - Set A = 32'h1111_1111, B = 32'h2222_2222, C = 32'h3333_3333 and step S through 0, 1, 2, 3 on successive edges.
  - Required Y after each edge: 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_0000.
- Latency / sampling:
  - With S = 1, change B from 5 to 7 between edges -> Y stays at its previous value until the next rising edge, then reads 7.
  - Changing A while S = 1 never affects Y.
- Async reset mid-run:
  - With Y = 32'hDEAD_BEEF, pull arst low between edges -> Y = 0 before any clock edge.
  - Release arst with S = 2 and C = 32'h0000_00C0 -> Y = 32'h0000_00C0 after the next edge.
- Random regression:
  - 128 cycles of random A, B, C with S = cycle index mod 4.
  - Compare every cycle against a reference model; Y must equal the value selected at the preceding edge, and 0 whenever S was 3.
- Bit integrity:
  - Walking-ones on each of A, B and C (bit 0..31) under the matching S -> Y reproduces every pattern exactly.
  - Bit 31 must not be sign-extended or dropped.
